uart_rx_core: RTL and testbench

- UART receiver for the FTDI_txd line (host to FPGA, 8N1).
- Sits directly upstream of the command/LM8 UART consumer inside top_XO2.
- Synchronises the asynchronous serial input, recovers bytes by mid-bit majority sampling, and presents them through a single-entry valid/ready holding register with framing and overrun flags.

---
 rtl/uart_rx_core.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_core.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, 3-sample majority, mid-bit sampling, single-entry valid/ready output.
// Define UART_RX_PARITY_EN to add a parity bit (ODD_PARITY selects odd/even) and the parity_err pulse.
module uart_rx_core #(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 115200,
`ifdef UART_RX_PARITY_EN
  parameter bit ODD_PARITY   = 1'b0,
`endif
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_err,
  output logic       overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  // state     | meaning
  // IDLE      | line idle, waiting for a low synchronised sample
  // START     | validating the start bit at its midpoint
  // DATA      | sampling 8 data bits, LSB first
  // PARITY    | sampling the parity bit (parity build only)
  // STOP      | sampling the stop bit, delivering the byte
  // WAIT_HIGH | framing error seen, waiting for the line to return high
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] MID_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] END_CNT = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state, state_nxt;
  logic             rx_s1, rx_s2;
  logic [2:0]       maj_sr;
  logic             maj;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             cnt_clr, cnt_run, bit_smp, stop_smp, byte_ok;
  logic             at_mid, at_end;
`ifdef UART_RX_PARITY_EN
  logic             par_smp, par_bad;
`endif

  assign maj    = (maj_sr[0] & maj_sr[1]) | (maj_sr[0] & maj_sr[2]) | (maj_sr[1] & maj_sr[2]);
  assign at_mid = (cnt == MID_CNT);
  assign at_end = (cnt == END_CNT);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_run   = 1'b0;
    bit_smp   = 1'b0;
    stop_smp  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_smp   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s2) begin
          state_nxt = START;
          cnt_clr   = 1'b1;
        end
      end
      START: begin
        cnt_run = 1'b1;
        if (at_mid) begin
          cnt_clr   = 1'b1;
          state_nxt = maj ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_run = 1'b1;
        if (at_end) begin
          cnt_clr = 1'b1;
          bit_smp = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == 3'd7) state_nxt = PARITY;
`else
          if (bit_cnt == 3'd7) state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        cnt_run = 1'b1;
        if (at_end) begin
          cnt_clr   = 1'b1;
          par_smp   = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        cnt_run = 1'b1;
        if (at_end) begin
          cnt_clr   = 1'b1;
          stop_smp  = 1'b1;
          state_nxt = maj ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_s2) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign byte_ok = stop_smp & maj & ~par_bad;
`else
  assign byte_ok = stop_smp & maj;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      maj_sr      <= 3'b111;
      cnt         <= '0;
      bit_cnt     <= 3'd0;
      shift       <= 8'h00;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      rx_s1  <= rxd_in;
      rx_s2  <= rx_s1;
      maj_sr <= {maj_sr[1:0], rx_s2};

      if (cnt_clr)      cnt <= '0;
      else if (cnt_run) cnt <= cnt + 1'b1;

      if (state == IDLE) bit_cnt <= 3'd0;
      else if (bit_smp)  bit_cnt <= bit_cnt + 3'd1;

      if (bit_smp) shift <= {maj, shift[7:1]};

`ifdef UART_RX_PARITY_EN
      // Parity checked over data plus parity bit; an even total is correct unless ODD_PARITY.
      if (par_smp) par_bad <= ((^shift) ^ maj) != ODD_PARITY;
      parity_err <= stop_smp & par_bad;
`endif
      framing_err <= stop_smp & ~maj;
      overrun_err <= byte_ok & rx_valid & ~rx_ready;

      // A completing byte may replace the held one only if that one is consumed this cycle.
      if (byte_ok && (!rx_valid || rx_ready)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (!byte_ok && rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 12 MHz / 115200 baud; frames driven bit-by-bit on negedges.
// Parity cases are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_core;
  localparam int CPB = 104;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Negedge index within a frame at which the stop sample cycle occurs.
  localparam int DONE_NEG = 3 + (CPB / 2 - 1) + (NB - 1) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, framing_err, overrun_err, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_core #(.CLK_HZ(12000000), .BAUD(115200)) dut (
    .clk(clk),
    .rst(rst),
    .rxd_in(rxd_in),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .framing_err(framing_err),
    .overrun_err(overrun_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int v_cyc = 0, v_rise = 0, fe_cyc = 0, oe_cyc = 0, pe_cyc = 0;
  logic       prev_v = 1'b0;
  logic [7:0] last_data = 8'h00;

  always @(negedge clk) begin
    v_cyc  += int'(rx_valid);
    fe_cyc += int'(framing_err);
    oe_cyc += int'(overrun_err);
`ifdef UART_RX_PARITY_EN
    pe_cyc += int'(parity_err);
`endif
    if (rx_valid && !prev_v) begin
      v_rise   += 1;
      last_data = rx_data;
    end
    prev_v = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] mk(input logic [7:0] d, input logic stop_b);
`ifdef UART_RX_PARITY_EN
    return {stop_b, ^d, d, 1'b0};
`else
    return {stop_b, d, 1'b0};
`endif
  endfunction

  // Drives one frame, one bit per CPB negedges; optionally pulses rx_ready for one cycle.
  task automatic send_bits(input logic [NB-1:0] f, input int ready_at);
    for (int n = 0; n < NB * CPB; n++) begin
      @(negedge clk);
      rxd_in = f[n / CPB];
      if (ready_at >= 0 && n == ready_at)     rx_ready = 1'b1;
      if (ready_at >= 0 && n == ready_at + 1) rx_ready = 1'b0;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  int r0, c0, f0, o0;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_framing_err", 32'(framing_err), 32'd0);
    chk("reset_overrun_err", 32'(overrun_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte with consumer always ready
    rx_ready = 1'b1;
    r0 = v_rise; c0 = v_cyc;
    send_bits(mk(8'hA5, 1'b1), -1);
    settle();
    chk("a5_busy_low", 32'(busy), 32'd0);
    chk("a5_valid_rises", 32'(v_rise - r0), 32'd1);
    chk("a5_valid_one_cycle", 32'(v_cyc - c0), 32'd1);
    chk("a5_data", 32'(last_data), 32'hA5);
    chk("a5_no_framing", 32'(fe_cyc), 32'd0);
    chk("a5_no_overrun", 32'(oe_cyc), 32'd0);

    // Short low glitch: false start
    r0 = v_rise;
    @(negedge clk);
    rxd_in = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("glitch_busy_in_start", 32'(busy), 32'd1);
    rxd_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    #1;
    chk("glitch_back_idle", 32'(busy), 32'd0);
    chk("glitch_no_valid", 32'(v_rise - r0), 32'd0);
    chk("glitch_no_framing", 32'(fe_cyc), 32'd0);

    // Low stop bit followed by a held-low line, then a good frame
    r0 = v_rise;
    send_bits(mk(8'h3C, 1'b0), -1);
    repeat (3 * CPB) @(negedge clk);
    #1;
    chk("break_wait_high_busy", 32'(busy), 32'd1);
    rxd_in = 1'b1;
    repeat (CPB) @(negedge clk);
    #1;
    chk("break_framing_once", 32'(fe_cyc), 32'd1);
    chk("break_no_valid", 32'(v_rise - r0), 32'd0);
    chk("break_idle", 32'(busy), 32'd0);
    send_bits(mk(8'h81, 1'b1), -1);
    settle();
    chk("after_break_rise", 32'(v_rise - r0), 32'd1);
    chk("after_break_data", 32'(last_data), 32'h81);

    // Overrun: two bytes with the consumer stalled
    @(negedge clk);
    rx_ready = 1'b0;
    r0 = v_rise;
    send_bits(mk(8'h11, 1'b1), -1);
    send_bits(mk(8'h22, 1'b1), -1);
    settle();
    chk("ovr_data_held", 32'(rx_data), 32'h11);
    chk("ovr_valid_held", 32'(rx_valid), 32'd1);
    chk("ovr_pulse_once", 32'(oe_cyc), 32'd1);
    chk("ovr_single_rise", 32'(v_rise - r0), 32'd1);
    rx_ready = 1'b1;
    settle();
    chk("ovr_consume_clears", 32'(rx_valid), 32'd0);
    rx_ready = 1'b0;

    // Consume exactly in the completion cycle of the next byte
    r0 = v_rise; o0 = oe_cyc; f0 = fe_cyc;
    send_bits(mk(8'h33, 1'b1), -1);
    send_bits(mk(8'h55, 1'b1), DONE_NEG);
    settle();
    chk("simul_data", 32'(rx_data), 32'h55);
    chk("simul_valid", 32'(rx_valid), 32'd1);
    chk("simul_valid_never_fell", 32'(v_rise - r0), 32'd1);
    chk("simul_no_overrun", 32'(oe_cyc - o0), 32'd0);
    chk("simul_no_framing", 32'(fe_cyc - f0), 32'd0);
    rx_ready = 1'b1;
    settle();
    chk("simul_consumed", 32'(rx_valid), 32'd0);

`ifdef UART_RX_PARITY_EN
    r0 = v_rise;
    send_bits({1'b1, 1'b0, 8'h07, 1'b0}, -1);
    settle();
    chk("par_bad_pulse", 32'(pe_cyc), 32'd1);
    chk("par_bad_no_valid", 32'(v_rise - r0), 32'd0);
    send_bits({1'b1, 1'b1, 8'h07, 1'b0}, -1);
    settle();
    chk("par_ok_no_pulse", 32'(pe_cyc), 32'd1);
    chk("par_ok_rise", 32'(v_rise - r0), 32'd1);
    chk("par_ok_data", 32'(last_data), 32'h07);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
